seven_seg_scanner: RTL

//  Time-multiplexed hex display driver for an N-digit common-anode 7-segment display.

---
 rtl/seven_seg_scanner_if.sv | 21 ++
 rtl/seven_seg_scanner.sv | 68 ++++++
 2 files changed

// File: rtl/seven_seg_scanner_if.sv
// seven_seg_scanner_if: scan input, display value and active-low display drive for the scanner
interface seven_seg_scanner_if #(
   parameter int N_DIGITS = 8
);
   logic                        i_scan_clk;
   logic                        i_enable;
   logic [4*N_DIGITS-1:0]       i_value;
   logic [N_DIGITS-1:0]         i_dp;
   logic [N_DIGITS-1:0]         o_anodes;
   logic [6:0]                  o_segments;
   logic                        o_dp;
   logic [$clog2(N_DIGITS)-1:0] o_digit_idx;
   modport master (
      output i_scan_clk, i_enable, i_value, i_dp,
      input  o_anodes, o_segments, o_dp, o_digit_idx
   );
   modport slave (
      input  i_scan_clk, i_enable, i_value, i_dp,
      output o_anodes, o_segments, o_dp, o_digit_idx
   );
endinterface

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexed hex driver for a common-anode display, scan clock sampled as data
module seven_seg_scanner #(
   parameter int N_DIGITS      = 8,
   parameter bit BLANK_LEADING = 1'b1
) (
   input logic                i_clk,
   input logic                i_reset,
   seven_seg_scanner_if.slave bus
);
   localparam int IW = $clog2(N_DIGITS);
   localparam logic [6:0] SEG [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };
   logic                  r_s1, r_s2, r_prev;
   logic [IW-1:0]         r_idx;
   logic [4*N_DIGITS-1:0] r_shadow_val;
   logic [N_DIGITS-1:0]   r_shadow_dp;
   logic [N_DIGITS-1:0]   r_anodes;
   logic [6:0]            r_segments;
   logic                  r_dp;
   logic                  w_advance, w_wrap, w_blank;
   logic [3:0]            w_nib;
   logic [N_DIGITS-1:0]   w_zero_from;
   assign w_advance = r_s2 & ~r_prev & bus.i_enable;
   assign w_wrap    = r_idx == IW'(N_DIGITS - 1);
   // w_zero_from[k]: shadow nibbles k..N_DIGITS-1 are all zero
   for (genvar k = 0; k < N_DIGITS; k++) begin : g_zero
      if (k == N_DIGITS - 1) begin : g_top
         assign w_zero_from[k] = r_shadow_val[4*k +: 4] == 4'h0;
      end else begin : g_rest
         assign w_zero_from[k] = (r_shadow_val[4*k +: 4] == 4'h0) & w_zero_from[k+1];
      end
   end
   assign w_nib   = r_shadow_val[{r_idx, 2'b00} +: 4];
   assign w_blank = BLANK_LEADING && (r_idx != '0) && w_zero_from[r_idx];
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_s1         <= 1'b0;
         r_s2         <= 1'b0;
         r_prev       <= 1'b0;
         r_idx        <= '0;
         r_shadow_val <= '0;
         r_shadow_dp  <= '0;
         r_anodes     <= '1;
         r_segments   <= 7'h7F;
         r_dp         <= 1'b1;
      end else begin
         r_s1   <= bus.i_scan_clk;
         r_s2   <= r_s1;
         r_prev <= r_s2;
         if (w_advance) begin
            r_idx <= w_wrap ? '0 : r_idx + 1'b1;
            if (w_wrap) begin
               r_shadow_val <= bus.i_value;
               r_shadow_dp  <= bus.i_dp;
            end
         end
         r_anodes   <= bus.i_enable ? ~(N_DIGITS'(1) << r_idx) : '1;
         r_segments <= (bus.i_enable && !w_blank) ? SEG[w_nib] : 7'h7F;
         r_dp       <= bus.i_enable ? ~r_shadow_dp[r_idx] : 1'b1;
      end
   end
   assign bus.o_anodes    = r_anodes;
   assign bus.o_segments  = r_segments;
   assign bus.o_dp        = r_dp;
   assign bus.o_digit_idx = r_idx;
endmodule
